// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the general-purpose register bank.
package reg_bank_pkg;

   localparam int REG_WIDTH_DEF = 16;
   localparam int REG_DEPTH_DEF = 8;

   function automatic int sel_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/reg_read_port.sv
// One registered read port: DEPTH:1 select, write bypass, zero-register override,
// and the output data/valid flops.
module reg_read_port
   import reg_bank_pkg::*;
#(
   parameter int WIDTH     = REG_WIDTH_DEF,
   parameter int DEPTH     = REG_DEPTH_DEF,
   parameter int BYPASS    = 1,
   parameter int ZERO_REG0 = 0,
   localparam int SEL_W    = sel_width(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DEPTH-1:0][WIDTH-1:0] mem,
   input  logic                        wr_en,
   input  logic [SEL_W-1:0]            wr_sel,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic                        rd_en,
   input  logic [SEL_W-1:0]            rd_sel,
   output logic [WIDTH-1:0]            rd_data,
   output logic                        rd_valid
);

   logic [WIDTH-1:0] sel_val;
   logic [WIDTH-1:0] rd_data_d, rd_data_q;
   logic             rd_valid_d, rd_valid_q;

   // Zero override has priority over bypass so register 0 never leaks write data.
   always_comb begin
      sel_val = mem[rd_sel];
      if ((BYPASS != 0) && wr_en && (wr_sel == rd_sel)) begin
         sel_val = wr_data;
      end
      if ((ZERO_REG0 != 0) && (rd_sel == '0)) begin
         sel_val = '0;
      end
   end

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_en;
      if (rd_en) begin
         rd_data_d = sel_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: rtl/reg_bank.sv
// General-purpose register bank: storage array and write decode, feeding two
// independent registered read ports.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int WIDTH     = REG_WIDTH_DEF,
   parameter int DEPTH     = REG_DEPTH_DEF,
   parameter int BYPASS    = 1,
   parameter int ZERO_REG0 = 0,
   localparam int SEL_W    = sel_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en_a,
   input  logic [SEL_W-1:0] rd_sel_a,
   output logic [WIDTH-1:0] rd_data_a,
   output logic             rd_valid_a,
   input  logic             rd_en_b,
   input  logic [SEL_W-1:0] rd_sel_b,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_valid_b
);

   logic [DEPTH-1:0][WIDTH-1:0] mem_d, mem_q;

   // Writes to register 0 are discarded when it is hard-wired to zero.
   always_comb begin
      mem_d = mem_q;
      if (wr_en && !((ZERO_REG0 != 0) && (wr_sel == '0))) begin
         mem_d[wr_sel] = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   reg_read_port #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .BYPASS    (BYPASS),
      .ZERO_REG0 (ZERO_REG0)
   ) u_port_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem      (mem_q),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_data  (wr_data),
      .rd_en    (rd_en_a),
      .rd_sel   (rd_sel_a),
      .rd_data  (rd_data_a),
      .rd_valid (rd_valid_a)
   );

   reg_read_port #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .BYPASS    (BYPASS),
      .ZERO_REG0 (ZERO_REG0)
   ) u_port_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem      (mem_q),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_data  (wr_data),
      .rd_en    (rd_en_b),
      .rd_sel   (rd_sel_b),
      .rd_data  (rd_data_b),
      .rd_valid (rd_valid_b)
   );

endmodule
